// File: rtl/panda_risc_v_imem_loader_pkg.sv
// Shared types and AXI constants for the instruction-memory AXI loader.
package panda_risc_v_imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_DONE
  } state_e;

  localparam logic [1:0]  BURST_INCR = 2'b01;
  localparam logic [2:0]  SIZE_4B    = 3'b010;
  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam int unsigned FOUR_KB    = 4096;

endpackage

// File: rtl/panda_risc_v_imem_loader_blen.sv
// Burst length calculator: beats = min(remaining, MAX_BURST_LEN, words left in the 4 KB page).
module panda_risc_v_imem_loader_blen
  import panda_risc_v_imem_loader_pkg::*;
#(
  parameter int unsigned MAX_BURST_LEN = 16
) (
  input  logic [9:0]  i_word_lo,
  input  logic [15:0] i_remain,
  output logic [8:0]  o_beats
);

  localparam logic [10:0] PAGE_WORDS = 11'(FOUR_KB / 4);

  logic [10:0] w_to_bound;
  logic [15:0] w_min_len;
  logic [15:0] w_min_all;

  always_comb begin
    // i_word_lo is the word index inside the page, so this is 1..1024
    w_to_bound = PAGE_WORDS - {1'b0, i_word_lo};
    w_min_len  = (i_remain < 16'(MAX_BURST_LEN)) ? i_remain : 16'(MAX_BURST_LEN);
    w_min_all  = ({5'd0, w_to_bound} < w_min_len) ? {5'd0, w_to_bound} : w_min_len;
    o_beats    = w_min_all[8:0];
  end

endmodule

// File: rtl/panda_risc_v_imem_axi_loader.sv
// AXI4 write master that streams a program image into instruction memory in 4 KB-safe INCR bursts.
// Optional checksum of written words: define PANDA_IMEM_LOADER_CHKSUM_EN.
module panda_risc_v_imem_axi_loader
  import panda_risc_v_imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int unsigned MAX_BURST_LEN = 16,
  parameter int          SIM_DELAY     = 1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        load_start,
  input  logic [31:0] load_baseaddr,
  input  logic [15:0] load_word_n,
  output logic        load_busy,
  output logic        load_done,
  output logic        load_err,
  output logic [31:0] load_chksum,
  input  logic [31:0] s_data_data,
  input  logic        s_data_valid,
  output logic        s_data_ready,
  output logic [31:0] m_axi_awaddr,
  output logic [1:0]  m_axi_awburst,
  output logic [7:0]  m_axi_awlen,
  output logic [2:0]  m_axi_awsize,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wlast,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready
);

  if (MAX_BURST_LEN < 1 || MAX_BURST_LEN > 256 || SIM_DELAY < 0) begin : g_bad_param
    $error("panda_risc_v_imem_axi_loader: illegal parameter value");
  end

  state_e      r_state;
  state_e      w_state_nxt;
  logic [31:0] r_addr;
  logic [15:0] r_remain;
  logic [8:0]  r_beats;
  logic [8:0]  r_bcnt;
  logic        r_err;

  logic [8:0]  w_beats_calc;
  logic [15:0] w_remain_left;
  logic        w_start_acc;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_b_hs;
  logic        w_last_beat;
  logic        w_unused_baseaddr_lsb;

  assign w_unused_baseaddr_lsb = ^load_baseaddr[1:0];

  panda_risc_v_imem_loader_blen #(
    .MAX_BURST_LEN(MAX_BURST_LEN)
  ) u_blen (
    .i_word_lo(r_addr[11:2]),
    .i_remain (r_remain),
    .o_beats  (w_beats_calc)
  );

  assign w_start_acc   = (r_state == ST_IDLE) && load_start;
  assign w_aw_hs       = m_axi_awvalid && m_axi_awready;
  assign w_w_hs        = m_axi_wvalid && m_axi_wready;
  assign w_b_hs        = m_axi_bvalid && m_axi_bready;
  assign w_last_beat   = (r_bcnt == (r_beats - 9'd1));
  assign w_remain_left = r_remain - {7'd0, r_beats};
  assign load_err      = r_err;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Address/remaining only move at job start and after each B response, so the
  // burst calculator output is stable for the whole AW phase.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_addr   <= '0;
      r_remain <= '0;
      r_beats  <= '0;
      r_bcnt   <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_addr   <= BASE_ADDR + {load_baseaddr[31:2], 2'b00};
        r_remain <= load_word_n;
        r_err    <= 1'b0;
      end
      if (w_aw_hs) begin
        r_beats <= w_beats_calc;
        r_bcnt  <= '0;
      end
      if (w_w_hs) begin
        r_bcnt <= r_bcnt + 9'd1;
      end
      if (w_b_hs) begin
        if (m_axi_bresp != RESP_OKAY) begin
          r_err <= 1'b1;
        end
        r_addr   <= r_addr + {21'd0, r_beats, 2'b00};
        r_remain <= w_remain_left;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    load_busy     = 1'b0;
    load_done     = 1'b0;
    m_axi_awaddr  = r_addr;
    m_axi_awburst = BURST_INCR;
    m_axi_awsize  = SIZE_4B;
    m_axi_awlen   = '0;
    m_axi_awvalid = 1'b0;
    m_axi_wdata   = s_data_data;
    m_axi_wstrb   = '1;
    m_axi_wlast   = 1'b0;
    m_axi_wvalid  = 1'b0;
    s_data_ready  = 1'b0;
    m_axi_bready  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (load_start) begin
          w_state_nxt = (load_word_n == 16'd0) ? ST_DONE : ST_AW;
        end
      end
      ST_AW: begin
        load_busy     = 1'b1;
        m_axi_awvalid = 1'b1;
        m_axi_awlen   = w_beats_calc[7:0] - 8'd1;
        if (m_axi_awready) begin
          w_state_nxt = ST_W;
        end
      end
      ST_W: begin
        load_busy    = 1'b1;
        m_axi_wvalid = s_data_valid;
        s_data_ready = m_axi_wready;
        m_axi_wlast  = w_last_beat;
        if (s_data_valid && m_axi_wready && w_last_beat) begin
          w_state_nxt = ST_B;
        end
      end
      ST_B: begin
        load_busy    = 1'b1;
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          w_state_nxt = (w_remain_left != 16'd0) ? ST_AW : ST_DONE;
        end
      end
      ST_DONE: begin
        load_done   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

`ifdef PANDA_IMEM_LOADER_CHKSUM_EN
  logic [31:0] r_chksum;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_chksum <= '0;
    end else if (w_start_acc) begin
      r_chksum <= '0;
    end else if (w_w_hs) begin
      r_chksum <= r_chksum + m_axi_wdata;
    end
  end

  assign load_chksum = r_chksum;
`else
  assign load_chksum = '0;
`endif

endmodule
